// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, control-field encodings, FSM states and control word
package mips_ctrl_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, RTYPEWB, BRANCH, JUMP, ADDIEX, ADDIWB, ILLEGAL
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath signals; master is the controller
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
    logic [3:0] state;
    modport master (
        input  opcode, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
               regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp, state
    );
    modport slave (
        output opcode, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
               regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp, state
    );
endinterface

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: combinational state -> control word decoder
module ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            ADDIWB: ctrl.reg_write = 1'b1;
            ILLEGAL: ctrl.illegal_op = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main sequencing FSM of the multicycle MIPS core
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master bus
);
    state_t state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk)
        state_q <= reset ? IDLE : state_d;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = bus.memReady ? DECODE : FETCH;
            DECODE:
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = ILLEGAL;
                endcase
            MEMADR: state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = bus.memReady ? MEMWB : MEMRD;
            MEMWR:  state_d = bus.memReady ? FETCH : MEMWR;
            EXEC:   state_d = RTYPEWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    ctrl_out_decode u_dec (.state(state_q), .mem_ready(bus.memReady), .ctrl(ctrl));

    // write strobes are masked on a reset edge so an interrupted access never commits
    assign bus.pcWrite     = ctrl.pc_write & ~reset;
    assign bus.pcWriteCond = ctrl.pc_write_cond & ~reset;
    assign bus.irWrite     = ctrl.ir_write & ~reset;
    assign bus.memWrite    = ctrl.mem_write & ~reset;
    assign bus.regWrite    = ctrl.reg_write & ~reset;
    assign bus.iorD        = ctrl.iord;
    assign bus.memRead     = ctrl.mem_read;
    assign bus.memToReg    = ctrl.mem_to_reg;
    assign bus.regDst      = ctrl.reg_dst;
    assign bus.aluSrcA     = ctrl.alu_src_a;
    assign bus.aluSrcB     = ctrl.alu_src_b;
    assign bus.aluOp       = ctrl.alu_op;
    assign bus.pcSource    = ctrl.pc_source;
    assign bus.illegalOp   = ctrl.illegal_op;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench walking the FSM through each instruction class
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic [5:0] op;
        state_t     st;
    } cyc_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   mw_cnt, rw_cnt, ill_cnt;
    cyc_t q[$];
    logic [16:0] act;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master));

    assign act = {bus.pcWrite, bus.pcWriteCond, bus.iorD, bus.memRead, bus.memWrite,
                  bus.irWrite, bus.memToReg, bus.regDst, bus.regWrite, bus.aluSrcA,
                  bus.aluSrcB, bus.aluOp, bus.pcSource, bus.illegalOp};

    function automatic logic [16:0] exp_ctl(state_t st, logic rdy, logic rst);
        logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
        {asb, aop, psrc} = '0;
        case (st)
            FETCH:   begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            DECODE:  asb = 2'b11;
            MEMADR:  begin asa = 1; asb = 2'b10; end
            MEMRD:   begin mr = 1; iord = 1; end
            MEMWB:   begin rw = 1; m2r = 1; end
            MEMWR:   begin mw = 1; iord = 1; end
            EXEC:    begin asa = 1; aop = 2'b10; end
            RTYPEWB: begin rw = 1; rd = 1; end
            BRANCH:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            JUMP:    begin pw = 1; psrc = 2'b10; end
            ADDIEX:  begin asa = 1; asb = 2'b10; end
            ADDIWB:  rw = 1;
            ILLEGAL: ill = 1;
            default: ;
        endcase
        if (rst) {pw, pwc, irw, mw, rw} = '0;
        return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
    endfunction

    task automatic push(state_t st, logic rdy, logic [5:0] op, logic rst = 1'b0);
        q.push_back('{rst: rst, rdy: rdy, op: op, st: st});
    endtask

    task automatic fetch(int stalls);
        for (int i = 0; i < stalls; i++) push(FETCH, 1'b0, 6'($urandom));
        push(FETCH, 1'b1, 6'($urandom));
    endtask

    task automatic run_queue();
        cyc_t e;
        logic [16:0] exp;
        mw_cnt = 0; rw_cnt = 0; ill_cnt = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            reset = e.rst;
            bus.memReady = e.rdy;
            bus.opcode = e.op;
            #1;
            exp = exp_ctl(e.st, e.rdy, e.rst);
            checks++;
            if (bus.state !== e.st) begin
                errors++;
                $display("FAIL state: got %0d expected %0d", bus.state, e.st);
            end
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL ctrl in state %0d: got %h expected %h", e.st, act, exp);
            end
            checks++;
            if ((bus.pcWrite & bus.pcWriteCond) !== 1'b0 || (bus.memRead & bus.memWrite) !== 1'b0) begin
                errors++;
                $display("FAIL exclusivity: pcW=%b pcWC=%b mR=%b mW=%b expected no overlap",
                         bus.pcWrite, bus.pcWriteCond, bus.memRead, bus.memWrite);
            end
            mw_cnt += int'(bus.memWrite);
            rw_cnt += int'(bus.regWrite);
            ill_cnt += int'(bus.illegalOp);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) push(IDLE, 1'b1, 6'($urandom), 1'b1);
        push(IDLE, 1'b1, 6'($urandom));
        run_queue();
    endtask

    task automatic test_lw();
        fetch(0);
        push(DECODE, 1'b1, OP_LW);
        push(MEMADR, 1'b1, OP_LW);
        push(MEMRD, 1'b1, 6'($urandom));
        push(MEMWB, 1'b1, 6'($urandom));
        run_queue();
        checks++;
        if (rw_cnt !== 1) begin
            errors++;
            $display("FAIL lw regWrite cycles: got %0d expected 1", rw_cnt);
        end
    endtask

    task automatic test_sw();
        fetch(1);
        push(DECODE, 1'b1, OP_SW);
        push(MEMADR, 1'b1, OP_SW);
        for (int i = 0; i < 3; i++) push(MEMWR, 1'b0, 6'($urandom));
        push(MEMWR, 1'b1, 6'($urandom));
        run_queue();
        checks++;
        if (mw_cnt !== 4 || rw_cnt !== 0) begin
            errors++;
            $display("FAIL sw write cycles: memWrite=%0d regWrite=%0d expected 4 and 0", mw_cnt, rw_cnt);
        end
    endtask

    task automatic test_rtype_beq();
        fetch(0);
        push(DECODE, 1'b1, OP_RTYPE);
        push(EXEC, 1'b1, 6'($urandom));
        push(RTYPEWB, 1'b1, 6'($urandom));
        fetch(2);
        push(DECODE, 1'b1, OP_BEQ);
        push(BRANCH, 1'b1, 6'($urandom));
        run_queue();
    endtask

    task automatic test_jump_addi();
        fetch(0);
        push(DECODE, 1'b1, OP_J);
        push(JUMP, 1'b1, 6'($urandom));
        fetch(0);
        push(DECODE, 1'b1, OP_ADDI);
        push(ADDIEX, 1'b1, 6'($urandom));
        push(ADDIWB, 1'b1, 6'($urandom));
        run_queue();
    endtask

    task automatic test_illegal();
        fetch(0);
        push(DECODE, 1'b1, 6'b111111);
        push(ILLEGAL, 1'b1, 6'($urandom));
        fetch(0);
        run_queue();
        checks++;
        if (ill_cnt !== 1 || rw_cnt !== 0 || mw_cnt !== 0) begin
            errors++;
            $display("FAIL illegal: pulses=%0d regWrite=%0d memWrite=%0d expected 1 0 0", ill_cnt, rw_cnt, mw_cnt);
        end
    endtask

    task automatic test_reset_midstall();
        push(DECODE, 1'b1, OP_LW);
        push(MEMADR, 1'b1, OP_LW);
        push(MEMRD, 1'b0, 6'($urandom));
        push(MEMRD, 1'b0, 6'($urandom), 1'b1);
        push(IDLE, 1'b0, 6'($urandom));
        push(FETCH, 1'b1, 6'($urandom));
        run_queue();
        checks++;
        if (rw_cnt !== 0) begin
            errors++;
            $display("FAIL midstall reset regWrite cycles: got %0d expected 0", rw_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.memReady = 1'b1;
        bus.opcode = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_lw();
        test_sw();
        test_rtype_beq();
        test_jump_addi();
        test_illegal();
        test_reset_midstall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
